// File: rtl/piso_tx_pkg.sv
// Shared types and constants for the piso_tx serializer.
// PISO_TX_PARITY_EN adds a trailing even-parity bit to every frame.
package piso_tx_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

`ifdef PISO_TX_PARITY_EN
    localparam int unsigned PARITY_LEN = 1;
`else
    localparam int unsigned PARITY_LEN = 0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    // Total serial bits emitted per accepted word.
    function automatic int unsigned frame_len(input int unsigned width);
        return width + PARITY_LEN;
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Frame bit index counter: clears on a new word, saturates at LIMIT, flags the final bit.
module piso_bit_counter
    import piso_tx_pkg::*;
#(
    parameter int unsigned CW    = 3,
    parameter int unsigned LIMIT = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          done
);

    localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en && (count != LIMIT_C)) begin
            count <= count + CW'(1);
        end
    end

    assign done = (count == LIMIT_C);

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter, MSB first, with back-to-back framing.
// Define PISO_TX_PARITY_EN to append an even-parity bit after the data bits.
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             out,
    output logic             out_valid,
    output logic             last
);

    localparam int unsigned FRAME_LEN = frame_len(WIDTH);
    localparam int unsigned CW        = $clog2(WIDTH + 1);
    // Index of the bit just before the final one; last is registered one edge early.
    localparam int unsigned PRE_LAST  = (FRAME_LEN >= 2) ? FRAME_LEN - 2 : 0;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    count;
    logic             done;
    logic             accept;
    logic             cnt_en;
`ifdef PISO_TX_PARITY_EN
    logic             parity_bit;
`endif

    assign load_ready = !reset && ((state == IDLE) || last);
    assign accept     = load_valid && load_ready;
    assign cnt_en     = (state != IDLE) && !done && !accept;

    piso_bit_counter #(
        .CW    (CW),
        .LIMIT (FRAME_LEN - 1)
    ) u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .en    (cnt_en),
        .count (count),
        .done  (done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            out        <= 1'b0;
            out_valid  <= 1'b0;
            last       <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else if (accept) begin
            state      <= SHIFT;
            shreg      <= data_in << 1;
            out        <= data_in[WIDTH-1];
            out_valid  <= 1'b1;
            last       <= (FRAME_LEN == 1);
`ifdef PISO_TX_PARITY_EN
            parity_bit <= ^data_in;
`endif
        end else if (state != IDLE) begin
            if (done) begin
                state     <= IDLE;
                out       <= 1'b0;
                out_valid <= 1'b0;
                last      <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            end else if ((state == SHIFT) && (count == CW'(WIDTH - 1))) begin
                state <= PARITY;
                out   <= parity_bit;
                last  <= 1'b1;
`endif
            end else begin
                out   <= shreg[WIDTH-1];
                shreg <= shreg << 1;
                last  <= (count == CW'(PRE_LAST));
            end
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: directed vector table, loopback, and random traffic vs a queue model.
module tb_piso_tx;

    localparam int unsigned W = 4;
`ifdef PISO_TX_PARITY_EN
    localparam int unsigned PAR = 1;
`else
    localparam int unsigned PAR = 0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] data_in;
    logic         load_valid;
    logic         load_ready;
    logic         out;
    logic         out_valid;
    logic         last;
    logic [W-1:0] sipo;

    int errors = 0;
    int checks = 0;

    bit   mq[$];
    logic cur_r, cur_lv, cur_rdy;
    logic [W-1:0] cur_d;

    typedef struct {
        logic         r;
        logic         lv;
        logic [W-1:0] d;
        logic         eo;
        logic         ev;
        logic         el;
        logic         er;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .out        (out),
        .out_valid  (out_valid),
        .last       (last)
    );

    // Behavioural downstream deserializer fed by the serial stream.
    always @(posedge clk) begin
        if (out_valid) sipo <= {sipo[W-2:0], out};
    end

    function automatic vec_t mk(input logic r, input logic lv, input logic [W-1:0] d,
                                input logic eo, input logic ev, input logic el, input logic er);
        vec_t v;
        v.r = r; v.lv = lv; v.d = d; v.eo = eo; v.ev = ev; v.el = el; v.er = er;
        return v;
    endfunction

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkv(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs from the model: the queue holds every bit still to appear on out.
    task automatic model_exp(output logic eo, output logic ev, output logic el, output logic er);
        ev = (mq.size() > 0);
        el = (mq.size() == 1);
        eo = ev ? logic'(mq[0]) : 1'b0;
        er = !cur_r && (mq.size() <= 1);
    endtask

    // Called just after a negedge: drive inputs and let them settle.
    task automatic apply(input logic r, input logic lv, input logic [W-1:0] d);
        logic eo, ev, el;
        reset = r; load_valid = lv; data_in = d;
        cur_r = r; cur_lv = lv; cur_d = d;
        model_exp(eo, ev, el, cur_rdy);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic eo, ev, el, er;
        model_exp(eo, ev, el, er);
        check1({tag, ".out"}, out, eo);
        check1({tag, ".out_valid"}, out_valid, ev);
        check1({tag, ".last"}, last, el);
        check1({tag, ".load_ready"}, load_ready, er);
    endtask

    // Cross the rising edge and move the model forward by one cycle.
    task automatic advance();
        @(posedge clk);
        if (cur_r) begin
            mq.delete();
        end else begin
            if (mq.size() > 0) void'(mq.pop_front());
            if (cur_lv && cur_rdy) begin
                for (int i = W - 1; i >= 0; i--) mq.push_back(cur_d[i]);
                if (PAR != 0) mq.push_back(^cur_d);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic         seen_last;
        logic [W-1:0] exp_sipo;
        logic [W-1:0] ld;

`ifdef PISO_TX_PARITY_EN
        tbl.push_back(mk(1, 1, 4'b1111, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4'b1011, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0110, 1, 1, 1, 1));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 1, 1, 1));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 1));
`else
        // Reset ignores a load; basic 1011 frame.
        tbl.push_back(mk(1, 1, 4'b1111, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4'b1011, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 1));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 1));
        // Back-to-back 1011 then 0110.
        tbl.push_back(mk(0, 1, 4'b1011, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0110, 1, 1, 1, 1));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 1, 1, 1));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 1));
        // Load attempt while busy is dropped.
        tbl.push_back(mk(0, 1, 4'b1001, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'b1111, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 1));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 1));
        // Reset mid-frame aborts, then a fresh 0001 frame.
        tbl.push_back(mk(0, 1, 4'b1011, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 4'b0000, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0001, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 1));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 1));
`endif

        reset = 1'b1; load_valid = 1'b0; data_in = '0;
        @(negedge clk);
        apply(1, 0, '0);
        advance();

        foreach (tbl[i]) begin
            apply(tbl[i].r, tbl[i].lv, tbl[i].d);
            check1($sformatf("tbl[%0d].out", i), out, tbl[i].eo);
            check1($sformatf("tbl[%0d].out_valid", i), out_valid, tbl[i].ev);
            check1($sformatf("tbl[%0d].last", i), last, tbl[i].el);
            check1($sformatf("tbl[%0d].load_ready", i), load_ready, tbl[i].er);
            advance();
        end

        // Loopback into a deserializer: the last W serial bits must rebuild the frame tail.
        ld = 4'b1011;
        apply(0, 1, ld);
        check_model("loop.load");
        advance();
        seen_last = 1'b0;
        for (int i = 0; i < int'(W + PAR) + 4; i++) begin
            apply(0, 0, '0);
            check_model($sformatf("loop[%0d]", i));
            if (last === 1'b1) begin
                advance();
                seen_last = 1'b1;
                break;
            end
            advance();
        end
        check1("loop.last_seen", seen_last, 1'b1);
        exp_sipo = (PAR != 0) ? {ld[W-2:0], ^ld} : ld;
        checkv("loop.sipo", sipo, exp_sipo);

        // Random traffic with occasional resets against the queue model.
        for (int c = 0; c < 400; c++) begin
            apply(logic'($urandom_range(0, 39) == 0), logic'($urandom_range(0, 1)), W'($urandom));
            check_model($sformatf("rand[%0d]", c));
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
